div_unit_32bit: RTL

DIV_UNIT_32BIT -- requirements
Module: div_unit_32bit

---
 rtl/div_unit_32bit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/div_unit_32bit.sv
// 32-bit iterative divider (DIV/DIVU/REM/REMU): restoring, 1 bit/cycle, done_o 34 cycles after the accepting edge.
// Optional DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow finish with latency 1; start_i is ignored while busy_o is high.
module div_unit_32bit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] rem_q, rem_d, quot_q, quot_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;

    logic        accept, is_signed, div_zero, sgn_ovf;
    logic [31:0] b_mag, q_fix, r_fix, fix_result, trial_diff;
    logic [32:0] rem_sh;
    logic        no_borrow;

    assign accept    = start_i && (state_q == IDLE || state_q == DONE);
    assign is_signed = ~op_q[0];
    assign b_mag     = (is_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
    assign div_zero  = (b_q == 32'd0);
    assign sgn_ovf   = is_signed && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);

    // Trial subtraction; the difference fits 32 bits whenever no borrow occurs.
    assign rem_sh     = {rem_q, quot_q[31]};
    assign no_borrow  = (rem_sh >= {1'b0, b_mag});
    assign trial_diff = rem_sh[31:0] - b_mag;

    always_comb begin
        q_fix = (is_signed && (a_q[31] ^ b_q[31])) ? (32'd0 - quot_q) : quot_q;
        r_fix = (is_signed && a_q[31]) ? (32'd0 - rem_q) : rem_q;
        if (div_zero) begin
            q_fix = 32'hFFFF_FFFF;
            r_fix = a_q;
        end else if (sgn_ovf) begin
            q_fix = 32'h8000_0000;
            r_fix = 32'd0;
        end
        fix_result = op_q[1] ? r_fix : q_fix;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            CALC: begin
                if (cnt_q == 6'd32) begin
                    state_d = FIX;
                end else begin
                    rem_d  = no_borrow ? trial_diff : rem_sh[31:0];
                    quot_d = {quot_q[30:0], no_borrow};
                    cnt_d  = cnt_q + 6'd1;
                end
`ifdef DIV_FAST_SPECIAL_EN
                if (cnt_q == 6'd0 && (div_zero || sgn_ovf)) begin
                    state_d  = DONE;
                    result_d = fix_result;
                    done_d   = 1'b1;
                end
`endif
            end
            FIX: begin
                state_d  = DONE;
                result_d = fix_result;
                done_d   = 1'b1;
            end
            default: begin
                if (state_q == DONE) state_d = IDLE;
            end
        endcase

        // Accept only from IDLE/DONE; the dividend magnitude seeds the quotient shifter.
        if (accept) begin
            state_d = CALC;
            cnt_d   = 6'd0;
            op_d    = op_i;
            a_d     = a_i;
            b_d     = b_i;
            rem_d   = 32'd0;
            quot_d  = (~op_i[0] && a_i[31]) ? (32'd0 - a_i) : a_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            op_q     <= 2'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            rem_q    <= 32'd0;
            quot_q   <= 32'd0;
            result_q <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign busy_o   = (state_q == CALC) || (state_q == FIX);
    assign done_o   = done_q;
    assign result_o = result_q;
endmodule
